imem_boot_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle 32-bit RISC CPU and its instruction memory. It accepts a byte stream over a valid/ready handshake and parses a length header. It assembles little-endian 32-bit words, writes them through the instruction-memory write port, and verifies a checksum. The CPU is held in reset until a successful load completes.

---
 rtl/boot_pkg.sv | 27 ++
 rtl/imem_word_packer.sv | 30 +++
 rtl/imem_boot_loader.sv | 111 +++++++++++
 tb/tb_imem_boot_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the loader top and its word packer.
package boot_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    LOAD,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int         HDR_BYTES = 2;
  localparam logic [7:0] CSUM_OK   = 8'h00;

  // A word count is usable when it is non-zero and fits the memory.
  function automatic logic len_ok(
    input logic [15:0] n,
    input int          aw
  );
    logic [16:0] cap;
    cap = 17'd1 << aw;
    return (n != 16'd0) && ({1'b0, n} <= cap);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles accepted stream bytes into little-endian 32-bit words.
// word is valid combinationally in the cycle the 4th byte is presented.
module imem_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] sreg;
  logic [1:0]  cnt;

  assign word       = {data, sreg[31:8]};
  assign word_valid = byte_valid && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (clear) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (byte_valid) begin
      sreg <= word;
      cnt  <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes the
// instruction memory and releases the CPU after a good checksum.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_Valid,
  output logic              Rx_Ready,
  output logic              Imem_We,
  output logic [ADDR_W-1:0] Imem_Addr,
  output logic [31:0]       Imem_Wdata,
  output logic              Cpu_Rst,
  output logic              Load_Done,
  output logic              Load_Err
);

  state_t      state;
  logic [15:0] count;
  logic [15:0] widx;
  logic [7:0]  sum;
  logic [7:0]  sum_n;
  logic        accept;
  logic        word_valid;
  logic [31:0] word;

  assign accept = Rx_Valid && Rx_Ready;
  assign sum_n  = sum + Rx_Data;

  imem_word_packer u_packer (
    .clk        (Clk),
    .clear      (Rst),
    .byte_valid (accept && (state == LOAD)),
    .data       (Rx_Data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= HDR_LO;
      count      <= '0;
      widx       <= '0;
      sum        <= '0;
      Rx_Ready   <= 1'b0;
      Imem_We    <= 1'b0;
      Imem_Addr  <= '0;
      Imem_Wdata <= '0;
      Cpu_Rst    <= 1'b1;
      Load_Done  <= 1'b0;
      Load_Err   <= 1'b0;
    end else begin
      Imem_We  <= word_valid;
      Cpu_Rst  <= (state != DONE);
      Rx_Ready <= (state != DONE) && (state != ERR);
      // Wdata has its own register so the next word cannot disturb it.
      if (word_valid)
        Imem_Wdata <= word;
      if (Imem_We)
        Imem_Addr <= Imem_Addr + 1'b1;
      if (accept)
        sum <= sum_n;
      unique case (state)
        HDR_LO: begin
          if (accept) begin
            count[7:0] <= Rx_Data;
            state      <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (accept) begin
            count[15:8] <= Rx_Data;
            if (len_ok({Rx_Data, count[7:0]}, ADDR_W)) begin
              state <= LOAD;
            end else begin
              state    <= ERR;
              Load_Err <= 1'b1;
              Rx_Ready <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (word_valid) begin
            widx <= widx + 16'd1;
            if (widx == 16'(count - 16'd1))
              state <= CSUM;
          end
        end
        CSUM: begin
          if (accept) begin
            Rx_Ready <= 1'b0;
            if (sum_n == CSUM_OK) begin
              state     <= DONE;
              Load_Done <= 1'b1;
            end else begin
              state    <= ERR;
              Load_Err <= 1'b1;
            end
          end
        end
        DONE: state <= DONE;
        ERR:  state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the boot loader: 256-word and 4-word instances.
// Writes are logged at the memory edge and compared to hand values.
module tb_imem_boot_loader;
  import boot_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8 = 1'b1, v8 = 1'b0;
  logic [7:0]  d8 = '0;
  logic        rdy8, we8, cr8, dn8, er8;
  logic [7:0]  addr8;
  logic [31:0] wdat8;

  logic        rst2 = 1'b1, v2 = 1'b0;
  logic [7:0]  d2 = '0;
  logic        rdy2, we2, cr2, dn2, er2;
  logic [1:0]  addr2;
  logic [31:0] wdat2;

  imem_boot_loader #(.ADDR_W(8)) u8 (
    .Clk(clk), .Rst(rst8), .Rx_Data(d8), .Rx_Valid(v8),
    .Rx_Ready(rdy8), .Imem_We(we8), .Imem_Addr(addr8),
    .Imem_Wdata(wdat8), .Cpu_Rst(cr8), .Load_Done(dn8),
    .Load_Err(er8)
  );

  imem_boot_loader #(.ADDR_W(2)) u2 (
    .Clk(clk), .Rst(rst2), .Rx_Data(d2), .Rx_Valid(v2),
    .Rx_Ready(rdy2), .Imem_We(we2), .Imem_Addr(addr2),
    .Imem_Wdata(wdat2), .Cpu_Rst(cr2), .Load_Done(dn2),
    .Load_Err(er2)
  );

  logic [31:0] qa8[$], qd8[$], qa2[$], qd2[$];

  always @(posedge clk) begin
    if (we8) begin
      qa8.push_back(32'(addr8));
      qd8.push_back(wdat8);
    end
    if (we2) begin
      qa2.push_back(32'(addr2));
      qd2.push_back(wdat2);
    end
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic send(input int u, input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    if (u == 8) begin d8 = b; v8 = 1'b1; end
    else begin d2 = b; v2 = 1'b1; end
    while (!(u == 8 ? rdy8 : rdy2) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    v2 = 1'b0;
  endtask

  // Present a byte for one cycle without waiting for acceptance.
  task automatic poke8(input logic [7:0] b);
    @(negedge clk);
    d8 = b;
    v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic do_rst(input int u);
    @(negedge clk);
    if (u == 8) rst8 = 1'b1; else rst2 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    rst2 = 1'b0;
    qa8.delete(); qd8.delete();
    qa2.delete(); qd2.delete();
  endtask

  task automatic chk_rst8(input string tag);
    chk({tag, "_rdy"}, 32'(rdy8), 32'd0);
    chk({tag, "_we"}, 32'(we8), 32'd0);
    chk({tag, "_addr"}, 32'(addr8), 32'd0);
    chk({tag, "_wdata"}, wdat8, 32'd0);
    chk({tag, "_cpurst"}, 32'(cr8), 32'd1);
    chk({tag, "_done"}, 32'(dn8), 32'd0);
    chk({tag, "_err"}, 32'(er8), 32'd0);
  endtask

  logic [7:0] hp[11];
  logic [7:0] cap4[19];

  initial begin
    hp = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h33, 8'h01, 8'h00, 8'h00, 8'hB7};
    // N=4, word i = i+1; sum 04+01+02+03+04 = 0x0E -> 0xF2
    cap4 = '{8'h04, 8'h00,
             8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
             8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
             8'hF2};

    repeat (3) @(negedge clk);
    chk_rst8("reset");
    rst8 = 1'b0;
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", 32'(rdy8), 32'd1);

    // Happy path with write-latency and Cpu_Rst timing.
    for (int i = 0; i < 6; i++) send(8, hp[i]);
    chk("w0_we", 32'(we8), 32'd1);
    chk("w0_addr", 32'(addr8), 32'd0);
    chk("w0_data", wdat8, 32'h00000013);
    for (int i = 6; i < 10; i++) send(8, hp[i]);
    chk("w1_we", 32'(we8), 32'd1);
    chk("w1_addr", 32'(addr8), 32'd1);
    chk("w1_data", wdat8, 32'h00000133);
    send(8, hp[10]);
    chk("hp_done", 32'(dn8), 32'd1);
    chk("hp_err", 32'(er8), 32'd0);
    chk("hp_rdy", 32'(rdy8), 32'd0);
    chk("hp_we_off", 32'(we8), 32'd0);
    chk("hp_cpurst_edge", 32'(cr8), 32'd1);
    @(posedge clk);
    #1;
    chk("hp_cpurst_next", 32'(cr8), 32'd0);
    chk("hp_nwr", 32'(qa8.size()), 32'd2);
    if (qa8.size() == 2) begin
      chk("hp_a0", qa8[0], 32'd0);
      chk("hp_d0", qd8[0], 32'h00000013);
      chk("hp_a1", qa8[1], 32'd1);
      chk("hp_d1", qd8[1], 32'h00000133);
    end

    // Bad checksum.
    do_rst(8);
    for (int i = 0; i < 10; i++) send(8, hp[i]);
    send(8, 8'hB8);
    chk("bc_err", 32'(er8), 32'd1);
    chk("bc_done", 32'(dn8), 32'd0);
    chk("bc_rdy", 32'(rdy8), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bc_cpurst", 32'(cr8), 32'd1);
    chk("bc_nwr", 32'(qa8.size()), 32'd2);

    // Bad length: zero words.
    do_rst(8);
    send(8, 8'h00);
    send(8, 8'h00);
    chk("len0_err", 32'(er8), 32'd1);
    chk("len0_rdy", 32'(rdy8), 32'd0);
    for (int i = 0; i < 6; i++) poke8(8'(8'h11 * i));
    chk("len0_nwr", 32'(qa8.size()), 32'd0);
    chk("len0_done", 32'(dn8), 32'd0);

    // Bad length: 257 words.
    do_rst(8);
    send(8, 8'h01);
    send(8, 8'h01);
    chk("len257_err", 32'(er8), 32'd1);
    chk("len257_rdy", 32'(rdy8), 32'd0);
    for (int i = 0; i < 6; i++) poke8(8'h5A);
    chk("len257_nwr", 32'(qa8.size()), 32'd0);
    chk("len257_cpurst", 32'(cr8), 32'd1);

    // Throttled source: at least one idle cycle before each byte.
    do_rst(8);
    for (int i = 0; i < 11; i++) begin
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      send(8, hp[i]);
    end
    chk("thr_done", 32'(dn8), 32'd1);
    chk("thr_nwr", 32'(qa8.size()), 32'd2);
    if (qa8.size() == 2) begin
      chk("thr_a0", qa8[0], 32'd0);
      chk("thr_d0", qd8[0], 32'h00000013);
      chk("thr_a1", qa8[1], 32'd1);
      chk("thr_d1", qd8[1], 32'h00000133);
    end

    // Reset mid-load, then a full reload.
    do_rst(8);
    for (int i = 0; i < 6; i++) send(8, hp[i]);
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    chk_rst8("midrst");
    @(negedge clk);
    rst8 = 1'b0;
    qa8.delete(); qd8.delete();
    for (int i = 0; i < 11; i++) send(8, hp[i]);
    chk("mr_done", 32'(dn8), 32'd1);
    chk("mr_nwr", 32'(qa8.size()), 32'd2);
    if (qa8.size() > 0) begin
      chk("mr_a0", qa8[0], 32'd0);
      chk("mr_d0", qd8[0], 32'h00000013);
    end

    // Capacity boundary on the 4-word instance.
    do_rst(2);
    for (int i = 0; i < 19; i++) send(2, cap4[i]);
    chk("cap4_done", 32'(dn2), 32'd1);
    chk("cap4_err", 32'(er2), 32'd0);
    chk("cap4_nwr", 32'(qa2.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < qa2.size()) begin
        chk($sformatf("cap4_a%0d", i), qa2[i], 32'(i));
        chk($sformatf("cap4_d%0d", i), qd2[i], 32'(i + 1));
      end
    end

    do_rst(2);
    send(2, 8'h05);
    send(2, 8'h00);
    chk("cap5_err", 32'(er2), 32'd1);
    chk("cap5_rdy", 32'(rdy2), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("cap5_nwr", 32'(qa2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
